// File: rtl/operand_stage.sv
// RV32I decode-to-execute operand stage: register file addressing, EX/MEM/WB bypass,
// load-use bubble insertion and the ID/EX pipeline register behind a valid/ready handshake.
module operand_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [4:0]  in_rd,
   input  logic        in_rd_we,
   input  logic        in_is_load,
   output logic [4:0]  rf_addr1,
   output logic [4:0]  rf_addr2,
   input  logic [31:0] rf_out1,
   input  logic [31:0] rf_out2,
   input  logic [31:0] ex_result,
   input  logic        mem_we,
   input  logic        mem_is_load,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_result,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [4:0]  out_rd,
   output logic        out_rd_we,
   output logic        out_is_load,
   output logic [31:0] out_op1,
   output logic [31:0] out_op2,
   output logic [15:0] stall_cycles
);

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned STALL_W = 16;
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   logic              ex_fwd;
   logic              load_in_ex;
   logic              hazard;
   logic              accept;
   logic              bubble;
   logic              drain;
   logic [WORD_W-1:0] op1_next;
   logic [WORD_W-1:0] op2_next;

   // Load data already arrives on mem_result, so the MEM load flag needs no use here.
   logic unused_mem_is_load;
   assign unused_mem_is_load = mem_is_load;

   // Nearest producer wins; x0 always reads as zero.
   function automatic logic [WORD_W-1:0] select_operand(
      input logic [REG_W-1:0]  rs,
      input logic [WORD_W-1:0] rf_data,
      input logic              ex_en,
      input logic [REG_W-1:0]  ex_rd,
      input logic [WORD_W-1:0] ex_data,
      input logic              mem_en,
      input logic [REG_W-1:0]  mem_dst,
      input logic [WORD_W-1:0] mem_data,
      input logic              wb_en,
      input logic [REG_W-1:0]  wb_dst,
      input logic [WORD_W-1:0] wb_data
   );
      if (rs == '0)                      return '0;
      else if (ex_en && ex_rd == rs)     return ex_data;
      else if (mem_en && mem_dst == rs)  return mem_data;
      else if (wb_en && wb_dst == rs)    return wb_data;
      else                               return rf_data;
   endfunction

   always_comb begin
      rf_addr1 = in_rs1;
      rf_addr2 = in_rs2;
   end

   always_comb begin
      ex_fwd   = out_valid & out_rd_we & ~out_is_load;
      op1_next = select_operand(in_rs1, rf_out1, ex_fwd, out_rd, ex_result,
                                mem_we, mem_rd, mem_result, wb_we, wb_rd, wb_result);
      op2_next = select_operand(in_rs2, rf_out2, ex_fwd, out_rd, ex_result,
                                mem_we, mem_rd, mem_result, wb_we, wb_rd, wb_result);
   end

   // Conservative load-use detection: either source field matching a pending load counts.
   always_comb begin
      load_in_ex = out_valid & out_is_load & out_rd_we & (out_rd != '0);
      hazard     = in_valid & load_in_ex & ((out_rd == in_rs1) | (out_rd == in_rs2));
      in_ready   = flush | ~(hazard | (out_valid & ~out_ready));
      accept     = in_valid & in_ready;
      bubble     = hazard & out_ready;
      drain      = out_valid & out_ready & ~in_valid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_rd       <= '0;
         out_rd_we    <= 1'b0;
         out_is_load  <= 1'b0;
         out_op1      <= '0;
         out_op2      <= '0;
         stall_cycles <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_pc      <= in_pc;
         out_rd      <= in_rd;
         out_rd_we   <= in_rd_we;
         out_is_load <= in_is_load;
         out_op1     <= op1_next;
         out_op2     <= op2_next;
      end else if (bubble) begin
         out_valid <= 1'b0;
         if (stall_cycles != STALL_MAX)
            stall_cycles <= stall_cycles + STALL_W'(1);
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_stage.sv
// Directed checks of operand_stage followed by a random instruction stream whose
// operands are checked against program-order register values.
module tb_operand_stage;

   localparam int NPROG = 200;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_rd_we, in_is_load;
   logic [4:0]  rf_addr1, rf_addr2;
   logic [31:0] rf_out1, rf_out2;
   logic [31:0] ex_result;
   logic        mem_we, mem_is_load;
   logic [4:0]  mem_rd;
   logic [31:0] mem_result;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic        out_valid, out_ready;
   logic [31:0] out_pc;
   logic [4:0]  out_rd;
   logic        out_rd_we, out_is_load;
   logic [31:0] out_op1, out_op2;
   logic [15:0] stall_cycles;

   operand_stage dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rd_we(in_rd_we), .in_is_load(in_is_load),
      .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_out1(rf_out1), .rf_out2(rf_out2),
      .ex_result(ex_result),
      .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_result(wb_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
      .out_rd_we(out_rd_we), .out_is_load(out_is_load),
      .out_op1(out_op1), .out_op2(out_op2), .stall_cycles(stall_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [4:0]  rs1, rs2, rd;
      logic        we, ld;
      logic [31:0] res, e1, e2;
   } ins_t;

   int          checks = 0;
   int          errors = 0;
   ins_t        prog [NPROG];
   logic [31:0] rf   [32];
   logic [31:0] gold [32];
   logic        m_we, m_ld, w_we, nm_we, nm_ld;
   logic [4:0]  m_rd, w_rd, nm_rd;
   logic [31:0] m_res, w_res, nm_res;
   int          issue, ret, cycles, idx;
   logic        fire_in, fire_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      flush = 0; in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      in_rd_we = 0; in_is_load = 0; rf_out1 = 0; rf_out2 = 0; ex_result = 0;
      mem_we = 0; mem_is_load = 0; mem_rd = 0; mem_result = 0;
      wb_we = 0; wb_rd = 0; wb_result = 0; out_ready = 1;
   endtask

   task automatic present(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we, input logic ld);
      in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_rd_we = we; in_is_load = ld;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state, then an asynchronous reset while the stage is holding an instruction.
      idle();
      reset = 0;
      #3;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_stall", 32'(stall_cycles), 0);
      chk("rst_op1", out_op1, 0);
      @(negedge clk);
      reset = 1;
      present(32'h100, 1, 0, 2, 1, 0);
      rf_out1 = 32'h11;
      out_ready = 0;
      cyc();
      chk("pre_rst_valid", 32'(out_valid), 1);
      chk("pre_rst_pc", out_pc, 32'h100);
      #2 reset = 0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_pc", out_pc, 0);
      chk("async_rst_op1", out_op1, 0);
      chk("async_rst_we", 32'(out_rd_we), 0);
      @(negedge clk);
      reset = 1;
      idle();
      present(32'h4, 5, 0, 1, 1, 0);
      rf_out1 = 7;
      chk("rf_addr1", 32'(rf_addr1), 5);
      cyc();
      chk("post_rst_op1", out_op1, 7);
      chk("post_rst_valid", 32'(out_valid), 1);

      // ALU result forwarded back-to-back from EX.
      idle();
      present(32'h8, 0, 0, 3, 1, 0);
      cyc();
      idle();
      present(32'hC, 3, 0, 9, 1, 0);
      ex_result = 42;
      #1 chk("alu_b2b_ready", 32'(in_ready), 1);
      cyc();
      chk("alu_b2b_op1", out_op1, 42);
      chk("alu_b2b_pc", out_pc, 32'hC);

      // Bypass priority EX > MEM > WB > register file.
      idle();
      present(32'h10, 0, 0, 4, 1, 0);
      cyc();
      present(32'h14, 0, 4, 9, 1, 0);
      ex_result = 1;
      mem_we = 1; mem_rd = 4; mem_result = 2;
      wb_we = 1; wb_rd = 4; wb_result = 3;
      rf_out2 = 32'h55;
      cyc();
      chk("prio_ex", out_op2, 1);
      present(32'h18, 0, 4, 9, 1, 0);
      cyc();
      chk("prio_mem", out_op2, 2);
      present(32'h1C, 0, 4, 9, 1, 0);
      mem_we = 0;
      cyc();
      chk("prio_wb", out_op2, 3);
      present(32'h20, 0, 4, 9, 1, 0);
      wb_we = 0;
      cyc();
      chk("prio_rf", out_op2, 32'h55);

      // Load-use: one bubble, then the load data comes from MEM.
      idle();
      present(32'h40, 0, 0, 6, 1, 1);
      cyc();
      present(32'h44, 6, 0, 7, 1, 0);
      #1 chk("lu_ready", 32'(in_ready), 0);
      cyc();
      chk("lu_bubble", 32'(out_valid), 0);
      chk("lu_stall", 32'(stall_cycles), 1);
      mem_we = 1; mem_rd = 6; mem_result = 99; mem_is_load = 1;
      #1 chk("lu_ready2", 32'(in_ready), 1);
      cyc();
      chk("lu_op1", out_op1, 99);
      chk("lu_pc", out_pc, 32'h44);

      // x0 never forwards and a load to x0 never stalls.
      idle();
      present(32'h48, 0, 0, 0, 1, 1);
      cyc();
      present(32'h4C, 0, 0, 0, 1, 0);
      ex_result = 7; rf_out1 = 8;
      mem_we = 1; mem_rd = 0; mem_result = 5;
      wb_we = 1; wb_rd = 0; wb_result = 6;
      #1 chk("x0_ready", 32'(in_ready), 1);
      cyc();
      chk("x0_op1_load", out_op1, 0);
      chk("x0_stall", 32'(stall_cycles), 1);
      present(32'h50, 0, 0, 10, 1, 0);
      cyc();
      chk("x0_op1_ex", out_op1, 0);
      chk("x0_op2_ex", out_op2, 0);

      // Downstream backpressure, then a flush that drops the presented instruction.
      idle();
      out_ready = 0;
      present(32'h60, 1, 2, 3, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_ready", 32'(in_ready), 0);
         cyc();
         chk("bp_pc", out_pc, 32'h50);
         chk("bp_valid", 32'(out_valid), 1);
      end
      flush = 1;
      in_pc = 32'h70;
      #1 chk("flush_ready", 32'(in_ready), 1);
      cyc();
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_stall", 32'(stall_cycles), 1);
      chk("flush_pc", out_pc, 32'h50);
      idle();
      cyc();
      chk("flush_after", 32'(out_valid), 0);

      // Random program: operands must equal the architectural values in program order.
      for (int r = 0; r < 32; r++) begin
         rf[r]   = (r == 0) ? 32'd0 : $urandom();
         gold[r] = rf[r];
      end
      for (int i = 0; i < NPROG; i++) begin
         prog[i].rs1 = 5'($urandom_range(0, 7));
         prog[i].rs2 = 5'($urandom_range(0, 7));
         prog[i].rd  = 5'($urandom_range(0, 7));
         prog[i].we  = ($urandom_range(0, 4) != 0);
         prog[i].ld  = ($urandom_range(0, 2) == 0);
         prog[i].res = $urandom();
         prog[i].e1  = gold[prog[i].rs1];
         prog[i].e2  = gold[prog[i].rs2];
         if (prog[i].we && prog[i].rd != 0) gold[prog[i].rd] = prog[i].res;
      end
      reset = 0;
      #1 reset = 1;
      m_we = 0; m_ld = 0; m_rd = 0; m_res = 0;
      w_we = 0; w_rd = 0; w_res = 0;
      issue = 0; ret = 0; cycles = 0;
      cyc();
      while (ret < NPROG && cycles < 4000) begin
         idle();
         if (issue < NPROG) begin
            present(32'(issue) << 2, prog[issue].rs1, prog[issue].rs2, prog[issue].rd,
                    prog[issue].we, prog[issue].ld);
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready   = ($urandom_range(0, 3) != 0);
         mem_we      = m_we; mem_is_load = m_ld; mem_rd = m_rd; mem_result = m_res;
         wb_we       = w_we; wb_rd = w_rd; wb_result = w_res;
         rf_out1     = rf[in_rs1];
         rf_out2     = rf[in_rs2];
         idx         = int'(out_pc >> 2);
         if (out_valid && !out_is_load && idx < NPROG) ex_result = prog[idx].res;
         else                                            ex_result = $urandom();
         #1;
         chk("rand_addr2", 32'(rf_addr2), 32'(in_rs2));
         fire_in  = in_valid & in_ready;
         fire_out = out_valid & out_ready;
         nm_we = 0; nm_ld = 0; nm_rd = 0; nm_res = 0;
         if (fire_out) begin
            chk("rand_pc", out_pc, 32'(ret) << 2);
            chk("rand_op1", out_op1, prog[ret].e1);
            chk("rand_op2", out_op2, prog[ret].e2);
            chk("rand_rd", 32'(out_rd), 32'(prog[ret].rd));
            chk("rand_flags", 32'({out_rd_we, out_is_load}), 32'({prog[ret].we, prog[ret].ld}));
            nm_we = prog[ret].we; nm_ld = prog[ret].ld;
            nm_rd = prog[ret].rd; nm_res = prog[ret].res;
            ret++;
         end
         @(posedge clk);
         if (w_we && w_rd != 0) rf[w_rd] = w_res;
         w_we = m_we; w_rd = m_rd; w_res = m_res;
         m_we = nm_we; m_ld = nm_ld; m_rd = nm_rd; m_res = nm_res;
         if (fire_in) issue++;
         cycles++;
         #1;
      end
      chk("rand_retired", 32'(ret), 32'(NPROG));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
